// File: rtl/tcp_check_sequencer.sv
// Beat tracker, word-strobe generator and in-order result hand-off for the TCP flag checker.
// Optional result timeout: define TCP_CHECK_SEQ_TIMEOUT_EN.
module tcp_check_sequencer #(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned TIMEOUT_CYC     = 64
) (
    input  logic                               axis_aclk,
    input  logic                               axis_resetn,
    input  logic                               in_tvalid,
    input  logic                               in_tready,
    input  logic                               in_tlast,
    output logic                               in_stall,
    output logic                               word_IP_DST_HI,
    output logic                               word_IP_DST_LO,
    output logic                               word_OPT_PAYLOAD,
    input  logic                               hand_shake_vld,
    output logic                               rd_check,
    input  logic                               res_req,
    output logic                               res_vld,
    output logic                               res_present,
    output logic                               res_err,
    output logic [$clog2(MAX_OUTSTANDING):0]   pending_cnt,
    output logic [CNT_W-1:0]                   pkt_cnt,
    output logic [CNT_W-1:0]                   short_cnt
);

    localparam int unsigned AW = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StW0, StW1, StW2, StPay} word_state_e;

    word_state_e                state_q;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [AW:0]                count_q, count_d;
    logic                       stall_q;
    logic [CNT_W-1:0]           pkt_cnt_q, short_cnt_q;

    logic beat, last_beat, full, push, pop, push_tag, head_valid, head_tag;

    assign beat      = in_tvalid & in_tready;
    assign last_beat = beat & in_tlast;

    assign word_IP_DST_HI   = (state_q == StW0) & beat;
    assign word_IP_DST_LO   = (state_q == StW1) & beat;
    assign word_OPT_PAYLOAD = (state_q == StW2) & beat;

    // A packet reaching the payload word has been fully seen by the checker.
    assign push_tag   = (state_q == StW2) | (state_q == StPay);
    assign full       = count_q == (AW + 1)'(MAX_OUTSTANDING);
    assign push       = last_beat & ~full;
    assign head_valid = count_q != '0;
    assign head_tag   = tag_q[rd_ptr_q];

`ifdef TCP_CHECK_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt_q;
    logic          err_q;
    logic          timed_out;

    assign timed_out   = to_cnt_q == TW'(TIMEOUT_CYC);
    assign res_err     = timed_out;
    assign res_present = head_valid & head_tag & hand_shake_vld & ~timed_out;
    assign res_vld     = (head_valid & (~head_tag | hand_shake_vld)) | timed_out;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (pop) begin
                to_cnt_q <= '0;
            end else if (head_valid & head_tag & ~hand_shake_vld & ~timed_out) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (pop & timed_out) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign res_err     = 1'b0;
    assign res_present = head_valid & head_tag & hand_shake_vld;
    assign res_vld     = head_valid & (~head_tag | hand_shake_vld);
`endif

    assign pop      = res_vld & res_req;
    assign rd_check = pop & res_present;
    assign count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= StW0;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_q     <= 1'b0;
            pkt_cnt_q   <= '0;
            short_cnt_q <= '0;
        end else begin
            if (beat) begin
                if (in_tlast) begin
                    state_q <= StW0;
                end else begin
                    unique case (state_q)
                        StW0:    state_q <= StW1;
                        StW1:    state_q <= StW2;
                        StW2:    state_q <= StPay;
                        default: state_q <= StPay;
                    endcase
                end
            end
            if (push) begin
                tag_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                pkt_cnt_q       <= pkt_cnt_q + 1'b1;
                if (!push_tag) begin
                    short_cnt_q <= short_cnt_q + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // A 3-beat packet needs one strobe-free cycle before the next packet starts.
            stall_q <= (count_d >= (AW + 1)'(MAX_OUTSTANDING - 1))
                     | (last_beat & (state_q == StW2));
        end
    end

    assign in_stall    = stall_q;
    assign pending_cnt = count_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign short_cnt   = short_cnt_q;

endmodule
